// File: rtl/output_vc_credit_tracker.sv
// Output-port VC state (FREE/ACTIVE/DRAIN) and per-VC downstream credit tracking.
// Latency: state and credit updates land one cycle after the request; outputs decode registered state.
// Backpressure: none; illegal allocs/sends and credit overflow are dropped and flag sticky err.
//
// Ports:
//   clk, rst (async, active-low)      clock and reset
//   alloc_req                         VC allocator claims the offered free VC
//   free_vc_valid / free_vc_idx       round-robin FREE VC offer
//   send_valid / send_vc / send_tail  departing flit
//   credit_valid / credit_vc          credit returned by the downstream router
//   credit_cnt                        per-VC credits, VC v at [v*CW +: CW]
//   vc_active / can_send / err        per-VC status and sticky protocol error
//
// Optional feature macro: CREDIT_ATOMIC_EN. When defined, a tail send parks the VC
// in DRAIN until all of its downstream credits have come back.
module output_vc_credit_tracker #(
    parameter int NUM_VC     = 4,
    parameter int VC_IDX_W   = 2,
    parameter int CREDIT_MAX = 4,
    parameter int CW         = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_req,
    output logic                 free_vc_valid,
    output logic [VC_IDX_W-1:0]  free_vc_idx,
    input  logic                 send_valid,
    input  logic [VC_IDX_W-1:0]  send_vc,
    input  logic                 send_tail,
    input  logic                 credit_valid,
    input  logic [VC_IDX_W-1:0]  credit_vc,
    output logic [NUM_VC*CW-1:0] credit_cnt,
    output logic [NUM_VC-1:0]    vc_active,
    output logic [NUM_VC-1:0]    can_send,
    output logic                 err
);

    typedef enum logic [1:0] {
        VC_FREE   = 2'd0,
        VC_ACTIVE = 2'd1,
        VC_DRAIN  = 2'd2
    } vc_state_e;

    localparam logic [CW-1:0] CMAX = CW'(CREDIT_MAX);

    vc_state_e            state_q  [NUM_VC];
    vc_state_e            state_d  [NUM_VC];
    logic [CW-1:0]        credit_q [NUM_VC];
    logic [CW-1:0]        credit_d [NUM_VC];
    logic [VC_IDX_W-1:0]  rr_q, rr_d;
    logic                 err_q, err_d;

    logic [VC_IDX_W-1:0]  cand_idx;
    logic                 legal_send;
    logic                 alloc_fire;
    logic [NUM_VC-1:0]    dec;
    logic [NUM_VC-1:0]    inc;

    // Status outputs decode registered state only.
    for (genvar v = 0; v < NUM_VC; v++) begin : g_out
        assign credit_cnt[v*CW +: CW] = credit_q[v];
        assign vc_active[v]           = (state_q[v] == VC_ACTIVE);
        assign can_send[v]            = (state_q[v] == VC_ACTIVE) && (credit_q[v] != '0);
    end
    assign err = err_q;

    // Round-robin free-VC search starting at rr_q, first hit wins.
    always_comb begin
        free_vc_valid = 1'b0;
        free_vc_idx   = '0;
        cand_idx      = '0;
        for (int k = 0; k < NUM_VC; k++) begin
            cand_idx = VC_IDX_W'((int'(rr_q) + k) % NUM_VC);
            if (!free_vc_valid && state_q[cand_idx] == VC_FREE) begin
                free_vc_valid = 1'b1;
                free_vc_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        legal_send = send_valid && can_send[send_vc];
        alloc_fire = alloc_req && free_vc_valid;
        err_d      = err_q;
        rr_d       = rr_q;
        dec        = '0;
        inc        = '0;

        if (alloc_req && !free_vc_valid) err_d = 1'b1;
        if (send_valid && !can_send[send_vc]) err_d = 1'b1;
        if (alloc_fire) rr_d = VC_IDX_W'((int'(free_vc_idx) + 1) % NUM_VC);

        for (int v = 0; v < NUM_VC; v++) begin
            state_d[v]  = state_q[v];
            credit_d[v] = credit_q[v];
            dec[v]      = legal_send && (send_vc == VC_IDX_W'(v));
            inc[v]      = credit_valid && (credit_vc == VC_IDX_W'(v));

            // A return onto a full counter is an overflow even if a send
            // on the same VC would have made room; the count stays saturated.
            if (inc[v]) begin
                if (credit_q[v] == CMAX) err_d = 1'b1;
                else if (!dec[v]) credit_d[v] = credit_q[v] + CW'(1);
            end else if (dec[v]) begin
                credit_d[v] = credit_q[v] - CW'(1);
            end

            case (state_q[v])
                VC_FREE: begin
                    if (alloc_fire && free_vc_idx == VC_IDX_W'(v)) state_d[v] = VC_ACTIVE;
                end
                VC_ACTIVE: begin
                    if (dec[v] && send_tail) begin
`ifdef CREDIT_ATOMIC_EN
                        state_d[v] = (credit_d[v] == CMAX) ? VC_FREE : VC_DRAIN;
`else
                        state_d[v] = VC_FREE;
`endif
                    end
                end
                VC_DRAIN: begin
                    // Released the cycle after the registered count reads full.
                    if (credit_q[v] == CMAX) state_d[v] = VC_FREE;
                end
                default: state_d[v] = VC_FREE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                state_q[v]  <= VC_FREE;
                credit_q[v] <= CMAX;
            end
            rr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                state_q[v]  <= state_d[v];
                credit_q[v] <= credit_d[v];
            end
            rr_q  <= rr_d;
            err_q <= err_d;
        end
    end

endmodule
